cv32e40p_fetch_sequencer: RTL
=============================

# cv32e40p_fetch_sequencer

Controller that sequences instruction fetches into the prefetch FIFO. It issues word-aligned bus read requests over an OBI-style address phase and tracks outstanding transactions so the FIFO never overflows. Responses are routed into the FIFO as push strobes. On a branch it flushes the FIFO and discards stale in-flight responses. It sits between the core's IF stage control and the prefetch FIFO/instruction bus interface.

## Interface
- DEPTH, 4: prefetch FIFO depth; also the maximum number of outstanding transactions (≥2).
- CNT_W, (DEPTH>1 ? $clog2(DEPTH) : 1)+1: width of the FIFO count input; derived, do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  1  fetch enable
- branch_i  in  1  single-cycle redirect strobe
- branch_addr_i  in  32  redirect target (bits [1:0] ignored)
- trans_valid_o  out  1  bus request valid
- trans_ready_i  in  1  bus request accepted
- trans_addr_o  out  32  bus request address, word-aligned
- resp_valid_i  in  1  bus read response valid (one per accepted request, in order)
- fifo_cnt_i  in  CNT_W  FIFO occupancy
- fifo_push_o  out  1  push response data into FIFO
- fifo_flush_o  out  1  flush FIFO
- busy_o  out  1  outstanding transactions or pending request exist

## Operation
- State machine states:
  - IDLE (reset state)
  - RUN
  - BRANCH_WAIT
- Registers and their reset values:
  - addr_q: 0
  - branch_addr_q: 0
  - outst_q (0..DEPTH): 0
  - discard_q (0..DEPTH): 0
  - pend_q: 0
- Acceptance: accept = trans_valid_o & trans_ready_i.
- Room check: room = (outst_q + fifo_cnt_i) < DEPTH. Evaluate at CNT_W+1 bits so there is no overflow.
- trans_valid_o = pend_q | (state==RUN & req_i & room).
- pend_q:
  - Set when trans_valid_o & ~trans_ready_i.
  - Cleared on accept.
  - Once trans_valid_o is high, it and trans_addr_o stay stable until accept. OBI rule; holds regardless of req_i and branch_i.
- trans_addr_o = addr_q. On accept in RUN, addr_q <= addr_q+4, wrapping 0xFFFF_FFFC → 0.
- outst_q update: +1 on accept, −1 on resp_valid_i, unchanged when both occur.
- Response routing:
  - fifo_push_o = resp_valid_i & (discard_q==0).
  - Otherwise the response is dropped and discard_q decrements.
- fifo_flush_o = branch_i, combinational, same cycle.
- Branch handling:
  - On branch_i, discard_q <= outst_q − resp_valid_i + (accept ? 1 : 0). This covers every response already owed.
  - If no pending-unaccepted request remains after this cycle, addr_q <= {branch_addr_i[31:2],2'b00} and state goes to RUN.
  - If a request is pending and not accepted this cycle, branch_addr_q <= target and state goes to BRANCH_WAIT.
- BRANCH_WAIT:
  - The stale request is held.
  - On its accept: discard_q increments (or is held if a discarded response arrives the same cycle), addr_q <= branch_addr_q, state goes to RUN.
  - A further branch_i here only overwrites branch_addr_q and flushes.
- IDLE:
  - trans_valid_o = 0.
  - Leaves only on branch_i: load target, go to RUN. The boot address arrives as a branch.
- RUN with req_i=0: no new requests. Outstanding responses still complete.
- busy_o = (outst_q != 0) | pend_q.

## Timing
- The first request is issued 1 cycle after branch_i: target registered, trans_valid_o high the next cycle if room.
- Back-to-back requests: one per cycle while room and trans_ready_i are high.
- Push latency: fifo_push_o is combinational from resp_valid_i (0 cycles).
- The FIFO count update is seen one cycle later. outst_q already reserves the slot, so the room check stays correct.
- Simultaneous events:
  - branch_i with resp_valid_i, when discard_q==0: the response is still dropped. fifo_push_o = resp_valid_i & (discard_q==0) & ~branch_i.
  - branch_i with accept in RUN: the accepted request counts toward discard.
- Boundaries:
  - outst_q never exceeds DEPTH; resp_valid_i with outst_q==0 is illegal.
  - discard_q ≤ outst_q at all times.
- Reset mid-operation: all registers clear asynchronously. trans_valid_o, fifo_push_o and busy_o are 0 from reset assertion.

## Test plan
- Reset, then branch_i with target 0x0000_1003, req_i=1, ready=1, no responses, DEPTH=4 → exactly 4 requests: 0x1000, 0x1004, 0x1008, 0x100C. trans_valid_o then low; busy_o=1.
- Responses return at 1/cycle with ready held high, fifo_cnt_i driven by a FIFO model with no pops → 4 pushes total. No 5th request until the FIFO is popped.
- 2 outstanding, then branch_i to 0x2000 → fifo_flush_o pulses 1 cycle. The next 2 responses do not push; requests resume at 0x2000, 0x2004.
- trans_ready_i=0 with request 0x100C pending, branch_i to 0x3000 → address held at 0x100C until ready. That response is discarded; the next request is 0x3000.
- branch_i in the same cycle as resp_valid_i and accept → no push. discard_q equals the outstanding count afterwards.
- Assert rst_ni low with 3 outstanding → all outputs are 0 immediately. After release the block stays IDLE until branch_i.

Source files
------------

// File: rtl/cv32e40p_fetch_sequencer.sv
// cv32e40p_fetch_sequencer
// Issues word-aligned instruction fetch requests on an OBI-style address
// phase, limits outstanding transactions so the prefetch FIFO cannot
// overflow, routes read responses into the FIFO as push strobes, and on a
// branch flushes the FIFO and drops every response still owed to the bus.
module cv32e40p_fetch_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = (DEPTH > 1 ? $clog2(DEPTH) : 1) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_addr_i,
    output logic             trans_valid_o,
    input  logic             trans_ready_i,
    output logic [31:0]      trans_addr_o,
    input  logic             resp_valid_i,
    input  logic [CNT_W-1:0] fifo_cnt_i,
    output logic             fifo_push_o,
    output logic             fifo_flush_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RUN         = 2'd1,
        BRANCH_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_addr;
    logic [31:0]      w_addr_nxt;
    logic [31:0]      r_branch_addr;
    logic [31:0]      w_branch_addr_nxt;
    logic [CNT_W-1:0] r_outst;
    logic [CNT_W-1:0] w_outst_nxt;
    logic [CNT_W-1:0] r_discard;
    logic [CNT_W-1:0] w_discard_nxt;
    logic             r_pend;
    logic             w_pend_nxt;

    logic [CNT_W:0]   w_occ;
    logic             w_room;
    logic             w_valid;
    logic             w_accept;
    logic             w_resp_drop;
    logic [31:0]      w_target;

    // Room check, request valid, acceptance and response classification
    always_comb begin
        w_occ       = {1'b0, r_outst} + {1'b0, fifo_cnt_i};
        w_room      = (w_occ < (CNT_W+1)'(DEPTH));
        w_valid     = r_pend | ((r_state == RUN) & req_i & w_room);
        w_accept    = w_valid & trans_ready_i;
        w_resp_drop = resp_valid_i & (r_discard != '0);
        w_target    = branch_addr_i & ~32'h0000_0003;
    end

    // Next-state and next-register computation
    always_comb begin
        w_state_nxt       = r_state;
        w_addr_nxt        = r_addr;
        w_branch_addr_nxt = r_branch_addr;
        w_pend_nxt        = w_valid & ~trans_ready_i;
        w_outst_nxt       = r_outst + CNT_W'(w_accept) - CNT_W'(resp_valid_i);
        w_discard_nxt     = r_discard - CNT_W'(w_resp_drop);

        case (r_state)
            IDLE: begin
                w_state_nxt = IDLE;
            end
            RUN: begin
                if (w_accept) begin
                    w_addr_nxt = r_addr + 32'd4;
                end
            end
            BRANCH_WAIT: begin
                // The held stale request finally goes out: its response is
                // owed too, so it joins the discard count.
                if (w_accept) begin
                    w_addr_nxt    = r_branch_addr;
                    w_discard_nxt = r_discard + CNT_W'(1) - CNT_W'(w_resp_drop);
                    w_state_nxt   = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A branch overrides the per-state updates: everything owed after
        // this cycle is discarded, and the target waits behind any request
        // that must stay on the bus unchanged until accepted.
        if (branch_i) begin
            w_discard_nxt = r_outst - CNT_W'(resp_valid_i) + CNT_W'(w_accept);
            if (w_pend_nxt) begin
                w_branch_addr_nxt = w_target;
                w_state_nxt       = BRANCH_WAIT;
            end else begin
                w_addr_nxt  = w_target;
                w_state_nxt = RUN;
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_branch_addr <= '0;
            r_outst       <= '0;
            r_discard     <= '0;
            r_pend        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_branch_addr <= w_branch_addr_nxt;
            r_outst       <= w_outst_nxt;
            r_discard     <= w_discard_nxt;
            r_pend        <= w_pend_nxt;
        end
    end

    assign trans_valid_o = w_valid;
    assign trans_addr_o  = r_addr;
    assign fifo_push_o   = rst_ni & resp_valid_i & (r_discard == '0) & ~branch_i;
    assign fifo_flush_o  = branch_i;
    assign busy_o        = (r_outst != '0) | r_pend;

    a_outst_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_outst <= CNT_W'(DEPTH));
    a_discard_le_outst: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_discard <= r_outst);
    a_no_stray_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        resp_valid_i |-> (r_outst != '0));
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (trans_valid_o && !trans_ready_i) |=> (trans_valid_o && $stable(trans_addr_o)));

endmodule
